// File: rtl/capture_pingpong_ctrl_pkg.sv
// Shared types and constants for the ADC ping-pong capture sequencer.
// Pure definitions: no latency, no backpressure.
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TRIG,
    CAPTURE,
    SWAP
  } cap_state_t;

  localparam int ADC_MID     = 512;
  localparam int FRAME_LEN   = 1024;
  localparam int DEF_TRIG_LO = 509;
  localparam int DEF_TRIG_HI = 513;

endpackage

// File: rtl/capture_pingpong_ctrl_trig.sv
// Midscale rising-crossing detector with a forced-trigger timeout.
// trig is combinational on the current sample; no backpressure, samples are never stalled.
module capture_trig
  import capture_pkg::*;
#(
  parameter int DW      = 10,
  parameter int TRIG_LO = DEF_TRIG_LO,
  parameter int TRIG_HI = DEF_TRIG_HI,
  parameter int TIMEOUT = 65535
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          run,
  input  logic          smp_valid,
  input  logic [DW-1:0] smp_data,
  output logic          trig
);

  localparam logic [DW-1:0] LO  = DW'(TRIG_LO);
  localparam logic [DW-1:0] HI  = DW'(TRIG_HI);
  localparam logic [15:0]   TMO = 16'(TIMEOUT);

  logic [DW-1:0] prev;
  logic [15:0]   tmo_cnt;
  logic          win_hit;
  logic          tmo_hit;

  assign win_hit = (prev < LO) && (smp_data >= LO) && (smp_data <= HI);
  assign tmo_hit = (TMO != 16'd0) && (tmo_cnt == TMO);
  // A forced trigger still needs a sample to become frame sample 0.
  assign trig    = run && smp_valid && (win_hit || tmo_hit);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      prev    <= '0;
      tmo_cnt <= '0;
    end else begin
      if (smp_valid) prev <= smp_data;
      if (!run || trig) tmo_cnt <= '0;
      else if (!tmo_hit) tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/capture_pingpong_ctrl.sv
// Triggered ADC frame capture into two RAM banks, handed to the FFT by start/done handshake.
// Writes land 1 cycle after the accepted sample; a trigger finding its bank full is dropped.
module capture_pingpong_ctrl
  import capture_pkg::*;
#(
  parameter int DW      = 10,
  parameter int AW      = 10,
  parameter int TRIG_LO = DEF_TRIG_LO,
  parameter int TRIG_HI = DEF_TRIG_HI,
  parameter int TIMEOUT = 65535
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          arm,
  input  logic          smp_valid,
  input  logic [DW-1:0] smp_data,
  output logic          wr_en,
  output logic          wr_bank,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          fft_start,
  output logic          fft_bank,
  input  logic          fft_done,
  output logic [1:0]    bank_full,
  output logic [15:0]   frame_cnt,
  output logic [15:0]   drop_cnt
);

  localparam logic [AW-1:0] LAST = '1;

  cap_state_t    state;
  logic          wbank;
  logic          fft_busy;
  logic [AW-1:0] addr_cnt;
  logic          trig;
  logic [DW-1:0] smp_conv;
  logic [1:0]    full_set;
  logic [1:0]    full_clr;
  logic          start_ok;
  logic          start_sel;

  assign smp_conv = {~smp_data[DW-1], smp_data[DW-2:0]};

  capture_trig #(
    .DW      (DW),
    .TRIG_LO (TRIG_LO),
    .TRIG_HI (TRIG_HI),
    .TIMEOUT (TIMEOUT)
  ) u_trig (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .run       (state == WAIT_TRIG),
    .smp_valid (smp_valid),
    .smp_data  (smp_data),
    .trig      (trig)
  );

  // SWAP and fft_done always target different banks, so both updates can merge.
  always_comb begin
    full_set  = 2'b00;
    full_clr  = 2'b00;
    if (state == SWAP) full_set = 2'b01 << wbank;
    if (fft_done && fft_busy) full_clr = 2'b01 << fft_bank;
    start_ok  = !fft_busy && (bank_full != 2'b00);
    start_sel = (&bank_full) ? ~wbank : bank_full[1];
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      wbank     <= 1'b0;
      fft_busy  <= 1'b0;
      addr_cnt  <= '0;
      wr_en     <= 1'b0;
      wr_bank   <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      fft_start <= 1'b0;
      fft_bank  <= 1'b0;
      bank_full <= 2'b00;
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      wr_en     <= 1'b0;
      fft_start <= 1'b0;
      bank_full <= (bank_full | full_set) & ~full_clr;

      case (state)
        IDLE: begin
          if (arm) state <= WAIT_TRIG;
        end
        WAIT_TRIG: begin
          if (trig) begin
            if (bank_full[wbank]) begin
              if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end else begin
              wr_en    <= 1'b1;
              wr_bank  <= wbank;
              wr_addr  <= '0;
              wr_data  <= smp_conv;
              addr_cnt <= AW'(1);
              state    <= CAPTURE;
            end
          end else if (!arm) begin
            state <= IDLE;
          end
        end
        CAPTURE: begin
          if (smp_valid) begin
            wr_en    <= 1'b1;
            wr_bank  <= wbank;
            wr_addr  <= addr_cnt;
            wr_data  <= smp_conv;
            addr_cnt <= addr_cnt + 1'b1;
            if (addr_cnt == LAST) state <= SWAP;
          end
        end
        SWAP: begin
          wbank <= ~wbank;
          state <= arm ? WAIT_TRIG : IDLE;
        end
        default: state <= IDLE;
      endcase

      if (start_ok) begin
        fft_start <= 1'b1;
        fft_bank  <= start_sel;
        fft_busy  <= 1'b1;
        frame_cnt <= frame_cnt + 16'd1;
      end else if (fft_done && fft_busy) begin
        fft_busy <= 1'b0;
      end
    end
  end

endmodule
